// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: resolves operand forwarding at capture, inserts
// load-use bubbles, and carries the valid/ready handshake with hold and flush.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic [4:0]      id_rd_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_use_imm,
   input  logic [3:0]      id_alu_op,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic [XLEN-1:0] alu_rd_value,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_value,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] rs1_value,
   output logic [XLEN-1:0] rs2_value,
   output logic [3:0]      alu_op,
   output logic [4:0]      ex_rd_addr,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic [XLEN-1:0] ex_store_data
);

   logic            hold;
   logic            hazard;
   logic            ex_fwd_ok;
   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;

   assign hold      = ex_valid & ~ex_ready;
   // rs2 is compared even for immediate forms: the store-data path still needs it
   assign hazard    = ex_valid & ex_mem_read & ex_reg_write & (ex_rd_addr != 5'd0) &
                      ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));
   assign id_ready  = ~hold & ~hazard;
   assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;

   function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      src,
                                               input logic [XLEN-1:0] rf_data);
      if (src == 5'd0)                                  return '0;
      else if (ex_fwd_ok && ex_rd_addr == src)          return alu_rd_value;
      else if (wb_reg_write && wb_rd_addr == src)       return wb_rd_value;
      else                                              return rf_data;
   endfunction

   always_comb begin
      fwd1 = fwd_sel(id_rs1_addr, id_rs1_data);
      fwd2 = fwd_sel(id_rs2_addr, id_rs2_data);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_rd_addr    <= '0;
         alu_op        <= '0;
         rs1_value     <= '0;
         rs2_value     <= '0;
         ex_store_data <= '0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
      end else if (hold) begin
         ex_valid <= ex_valid;
      end else if (id_valid && !hazard) begin
         ex_valid      <= 1'b1;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_rd_addr    <= id_rd_addr;
         alu_op        <= id_alu_op;
         rs1_value     <= fwd1;
         rs2_value     <= id_use_imm ? id_imm : fwd2;
         ex_store_data <= fwd2;
      end else begin
         // bubble: only the control bits die, the datapath keeps its last value
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
      end
   end

endmodule
